// File: rtl/xbus_scratchpad.sv
// xbus_scratchpad: word-addressed 32-bit scratchpad RAM plus a 32-bit access counter on a req/ack bus.
// Latency: XDACK is seen WAIT+1 cycles after the sampling edge; every halted cycle adds one.
// Backpressure: initiator holds XDREQ until XDACK; HLT freezes the FSM, the wait counter and the held ACK.
//
// Ports:
//   CLK          single clock, rising edge
//   RES          synchronous active-high reset
//   HLT          global halt (freezes FSM / wait counter, stretches ACK)
//   XDREQ        request, held high by the initiator until XDACK
//   XRD, XWR     read / write qualifiers (write wins when both set)
//   XBE[3:0]     byte enables for writes
//   XADDR[31:0]  byte address; [DEPTH_LOG2+1:2] word index, [29] selects the access counter
//   XATAI[31:0]  write data
//   XATAO[31:0]  read data, non-zero only in a read ACK cycle
//   XDACK        acknowledge, one cycle unless stretched by HLT
module xbus_scratchpad #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WAIT       = 2
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        HLT,
  input  logic        XDREQ,
  input  logic        XRD,
  input  logic        XWR,
  input  logic [3:0]  XBE,
  input  logic [31:0] XADDR,
  input  logic [31:0] XATAI,
  output logic [31:0] XATAO,
  output logic        XDACK
);

  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_L = 4'(WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_GAP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  sample;
  logic                  ack_fire;

  // Request fields captured at the sampling edge; later input changes are ignored.
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  ctr_sel_q;
  logic                  rd_q;
  logic                  wr_q;
  logic [3:0]            be_q;
  logic [31:0]           dat_q;

  logic [31:0]           acc_cnt_q;
  logic [31:0]           mem_q [DEPTH];

  // Address bits outside the word index and the counter select alias away.
  logic                  unused_addr;
  assign unused_addr = ^{XADDR[31:30], XADDR[28:DEPTH_LOG2+2], XADDR[1:0]};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    sample  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (XDREQ && !HLT) begin
          sample = 1'b1;
          if (WAIT == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_L;
          end
        end
      end
      S_WAIT: begin
        if (!HLT) begin
          wcnt_d = wcnt_q - 4'd1;
          // Leaving on the decrement from 1 gives WAIT+1 cycles to XDACK.
          if (wcnt_q == 4'd1) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (!HLT) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // XDREQ is ignored here so a request still high after XDACK is not re-acked.
        if (!HLT) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Side effects happen once, on the first non-halted ACK edge.
  assign ack_fire = (state_q == S_ACK) && !HLT;

  // ---------------------------------------------------------------- request latch
  always_ff @(posedge CLK) begin
    if (RES) begin
      idx_q     <= '0;
      ctr_sel_q <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      be_q      <= '0;
      dat_q     <= '0;
    end else if (sample) begin
      idx_q     <= XADDR[DEPTH_LOG2+1:2];
      ctr_sel_q <= XADDR[29];
      rd_q      <= XRD;
      wr_q      <= XWR;
      be_q      <= XBE;
      dat_q     <= XATAI;
    end
  end

  // ---------------------------------------------------------------- access counter
  // Counts completed array reads/writes; a counter write with any byte enable clears it.
  always_ff @(posedge CLK) begin
    if (RES) begin
      acc_cnt_q <= '0;
    end else if (ack_fire) begin
      if (ctr_sel_q) begin
        if (wr_q && (be_q != 4'd0)) begin
          acc_cnt_q <= '0;
        end
      end else if (rd_q || wr_q) begin
        acc_cnt_q <= acc_cnt_q + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------- array
  // Contents are not reset; a reset edge suppresses any pending write.
  always_ff @(posedge CLK) begin
    if (!RES && ack_fire && wr_q && !ctr_sel_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  // Read data is driven straight from state, so a counter read sees the pre-update value.
  always_comb begin
    XDACK = (state_q == S_ACK);
    XATAO = '0;
    if ((state_q == S_ACK) && rd_q && !wr_q) begin
      XATAO = ctr_sel_q ? acc_cnt_q : mem_q[idx_q];
    end
  end

endmodule

// File: tb/tb_xbus_scratchpad.sv
// Testbench for xbus_scratchpad: directed bus scenarios plus randomized traffic,
// checked by a scoreboard fed from an address-map reference model.
module tb_xbus_scratchpad;

  logic        CLK = 1'b0;
  logic        RES, HLT, XDREQ, XRD, XWR;
  logic [3:0]  XBE;
  logic [31:0] XADDR, XATAI;
  logic [31:0] XATAO;
  logic        XDACK;

  int compared = 0;
  int failed   = 0;

  logic [31:0] exp_q [$];

  // Reference model: the scratchpad as a plain word array plus an access count.
  logic [31:0] mdl_mem [64];
  logic [31:0] mdl_cnt = '0;

  xbus_scratchpad dut (
    .CLK   (CLK),
    .RES   (RES),
    .HLT   (HLT),
    .XDREQ (XDREQ),
    .XRD   (XRD),
    .XWR   (XWR),
    .XBE   (XBE),
    .XADDR (XADDR),
    .XATAI (XATAI),
    .XATAO (XATAO),
    .XDACK (XDACK)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
    $fatal(1);
  end

  // Apply one access to the model and return what XATAO should show in its ACK.
  function automatic logic [31:0] model_access(input logic [31:0] addr, input logic rd,
                                               input logic wr, input logic [3:0] be,
                                               input logic [31:0] dat);
    int w;
    w = int'((addr >> 2) % 64);
    if (wr) begin
      if (addr[29]) begin
        if (be != 4'd0) mdl_cnt = '0;
      end else begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl_mem[w][8*b +: 8] = dat[8*b +: 8];
        mdl_cnt = mdl_cnt + 32'd1;
      end
      return '0;
    end
    if (rd) begin
      if (addr[29]) return mdl_cnt;
      mdl_cnt = mdl_cnt + 32'd1;
      return mdl_mem[w];
    end
    return '0;
  endfunction

  // Monitor: on each new XDACK pop the expected read data; hold it while XDACK is stretched.
  logic        prev_dack = 1'b0;
  logic [31:0] held = '0;
  always @(negedge CLK) begin
    if (XDACK === 1'b1 && !prev_dack) begin
      if (exp_q.size() == 0) begin
        compared++;
        failed++;
        $display("FAIL unexpected_dack: XDACK=1 with XATAO=%h, required no acknowledge", XATAO);
        held = '0;
      end else begin
        held = exp_q.pop_front();
      end
    end
    compared++;
    if (XDACK === 1'b1) begin
      if (XATAO !== held) begin
        failed++;
        $display("FAIL ack_data: XATAO=%h, required %h", XATAO, held);
      end
    end else if (XATAO !== 32'd0 || XDACK !== 1'b0) begin
      failed++;
      $display("FAIL idle_outputs: XDACK=%b XATAO=%h, required 0/00000000", XDACK, XATAO);
    end
    prev_dack = (XDACK === 1'b1);
  end

  // One access. Called just after a negedge with the DUT idle. h halts WAIT cycles,
  // ah stretches the ACK. Inputs are scrambled right after the sampling edge.
  task automatic xfer(input logic [31:0] addr, input logic rd, input logic wr,
                      input logic [3:0] be, input logic [31:0] dat,
                      input int h, input int ah);
    int lat;
    bit got;
    exp_q.push_back(model_access(addr, rd, wr, be, dat));
    XDREQ = 1'b1; XADDR = addr; XRD = rd; XWR = wr; XBE = be; XATAI = dat;
    lat = 0;
    got = 0;
    while (!got && lat < 50) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        XADDR = $urandom; XATAI = $urandom; XBE = 4'($urandom);
        XRD = 1'($urandom); XWR = 1'($urandom);
      end
      if (XDACK === 1'b1) got = 1;
      else HLT = (lat <= h);
    end
    compared++;
    if (!got || lat != 3 + h) begin
      failed++;
      $display("FAIL latency: addr=%h took %0d cycles (acked=%0d), required %0d", addr, lat, got, 3 + h);
    end
    XDREQ = 1'b0;
    HLT = 1'b0;
    if (ah > 0) begin
      HLT = 1'b1;
      repeat (ah) @(negedge CLK);
      HLT = 1'b0;
    end
    repeat (2) @(negedge CLK);
  endtask

  // Read with XDREQ kept high past XDACK: expect exactly one re-sampled second access.
  task automatic held_read(input logic [31:0] addr);
    int lat;
    int gap;
    exp_q.push_back(model_access(addr, 1'b1, 1'b0, 4'hF, 32'd0));
    exp_q.push_back(model_access(addr, 1'b1, 1'b0, 4'hF, 32'd0));
    XDREQ = 1'b1; XADDR = addr; XRD = 1'b1; XWR = 1'b0; XBE = 4'hF;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (XDACK !== 1'b1 && lat < 50);
    gap = 0;
    do begin
      @(negedge CLK);
      gap++;
    end while (XDACK !== 1'b1 && gap < 50);
    compared++;
    if (lat != 3 || gap != 5) begin
      failed++;
      $display("FAIL held_req: first latency %0d, second XDACK after %0d cycles, required 3 and 5", lat, gap);
    end
    XDREQ = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  logic [31:0] r_addr, r_dat;
  logic        r_rd, r_wr;
  logic [3:0]  r_be;
  int          r_h, r_ah;

  initial begin
    RES = 1'b1; HLT = 1'b0; XDREQ = 1'b0; XRD = 1'b0; XWR = 1'b0;
    XBE = '0; XADDR = '0; XATAI = '0;
    repeat (3) @(negedge CLK);
    RES = 1'b0;

    // First request goes out on the first edge with RES low; fill every word.
    for (int i = 0; i < 64; i++)
      xfer(32'(i * 4), 1'b0, 1'b1, 4'hF, $urandom, 0, 0);

    // Full-word write/read, then byte-enable merge.
    xfer(32'h8, 1'b0, 1'b1, 4'hF, 32'hA5A5_1234, 0, 0);
    xfer(32'h8, 1'b1, 1'b0, 4'h3, 32'h0, 0, 0);
    xfer(32'h8, 1'b0, 1'b1, 4'b0101, 32'hFFFF_FFFF, 0, 0);
    xfer(32'h8, 1'b1, 1'b0, 4'h0, 32'h0, 0, 0);

    // Request held high across XDACK and GAP.
    held_read(32'h8);

    // Word 64 aliases word 0.
    xfer(32'h100, 1'b0, 1'b1, 4'hF, 32'h0000_CAFE, 0, 0);
    xfer(32'h0, 1'b1, 1'b0, 4'hF, 32'h0, 0, 0);

    // Reset during the WAIT of a write to word 5: aborted, no XDACK, counter cleared.
    XDREQ = 1'b1; XADDR = 32'h14; XRD = 1'b0; XWR = 1'b1; XBE = 4'hF; XATAI = 32'hDEAD_BEEF;
    @(negedge CLK);
    XDREQ = 1'b0;
    @(negedge CLK);
    RES = 1'b1;
    HLT = 1'b1;
    repeat (2) @(negedge CLK);
    RES = 1'b0;
    HLT = 1'b0;
    mdl_cnt = '0;
    repeat (3) @(negedge CLK);
    xfer(32'h14, 1'b1, 1'b0, 4'hF, 32'h0, 0, 0);

    // Counter: three array accesses since reset, then clear and no-op writes.
    xfer(32'h20, 1'b0, 1'b1, 4'hF, $urandom, 0, 0);
    xfer(32'h24, 1'b1, 1'b0, 4'hF, 32'h0, 0, 0);
    xfer(32'h2000_0000, 1'b1, 1'b0, 4'h0, 32'h0, 0, 0);
    xfer(32'h2000_0000, 1'b0, 1'b1, 4'b0001, 32'h0, 0, 0);
    xfer(32'h2000_0000, 1'b1, 1'b0, 4'h0, 32'h0, 0, 0);
    xfer(32'h2000_0004, 1'b0, 1'b1, 4'h0, 32'hFFFF_FFFF, 0, 0);
    xfer(32'h30, 1'b1, 1'b0, 4'hF, 32'h0, 0, 0);
    xfer(32'h2000_0000, 1'b1, 1'b0, 4'h0, 32'h0, 0, 0);

    // Halts in WAIT and in ACK: latency stretches, write and count happen once.
    xfer(32'h30, 1'b0, 1'b1, 4'b1001, 32'h1122_3344, 2, 3);
    xfer(32'h2000_0000, 1'b1, 1'b0, 4'h0, 32'h0, 0, 0);
    xfer(32'h30, 1'b1, 1'b1, 4'b0010, 32'h0000_5500, 0, 0);
    xfer(32'h30, 1'b1, 1'b0, 4'hF, 32'h0, 1, 2);

    // Randomized traffic; array accesses always read or write.
    for (int i = 0; i < 200; i++) begin
      r_addr = $urandom;
      r_addr[29] = ($urandom_range(0, 5) == 0);
      r_wr = 1'($urandom);
      r_rd = r_wr ? 1'($urandom) : 1'b1;
      r_be = 4'($urandom);
      r_dat = $urandom;
      r_h  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      r_ah = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      xfer(r_addr, r_rd, r_wr, r_be, r_dat, r_h, r_ah);
    end

    // Access with neither qualifier: acknowledged, no memory effect.
    xfer(32'h40, 1'b0, 1'b0, 4'hF, 32'h1234_5678, 0, 0);
    xfer(32'h40, 1'b1, 1'b0, 4'hF, 32'h0, 0, 0);

    repeat (4) @(negedge CLK);
    compared++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL pending: %0d expected acknowledges never arrived, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
